led_fade_driver: RTL and testbench
==================================

// Module: led_fade_driver
// PURPOSE
//  Downstream consumer of the rotating LED pattern. Each LED glows at full brightness
//  while its pattern bit is lit, then fades out over a programmable time.
//  Sits between the pattern shift register and the board LED pins.
//  Per-LED PWM output, active-low like the pattern and the pins.
// PARAMETERS
//  N_LED      8    number of LED channels
//  LVL_W      4    brightness level width; LVL_MAX = 2**LVL_W-1
//  PWM_W      8    PWM counter width; PWM period = 2**PWM_W clk cycles
//  DECAY_DIV  64   PWM periods per one-step level decrement (>=1)
// PORTS
//  clk          in   1      system clock
//  rst          in   1      synchronous reset, active-high
//  pattern      in   N_LED  LED pattern, active-low (0 = lit), sampled only on pattern_vld
//  pattern_vld  in   1      one-cycle strobe: pattern is valid this cycle
//  led_n        out  N_LED  registered PWM drive, active-low (0 = LED on)
//  active       out  1      registered; 1 while any channel level != 0
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): levels=0, pwm_cnt=0, decay_cnt=0,
//    led_n = all ones, active=0. Reset mid-fade aborts all fades immediately.
//  - pwm_cnt: free-running PWM_W-bit up-counter. Wraps 2**PWM_W-1 -> 0.
//    Each wrap is one PWM period.
//  - decay_cnt: counts PWM wraps 0..DECAY_DIV-1. On the wrap where it equals
//    DECAY_DIV-1 it returns to 0 and decay_tick pulses for one cycle.
//  - Per channel i, level update (priority order):
//    1) pattern_vld && pattern[i]==0 -> level=LVL_MAX; load wins over a same-cycle decay_tick.
//    2) else decay_tick && level!=0 -> level-1; saturates at 0, never wraps.
//    3) else hold. pattern_vld with pattern[i]==1 does not change level.
//  - Duty, linear: thr = level << (PWM_W-LVL_W).
//    LED on when pwm_cnt < thr. Exception: level==LVL_MAX -> on every cycle.
//    level==0 -> off every cycle.
//  - led_n[i] registered: 0 when on, 1 otherwise. active = registered OR-reduce of levels.
//  - Latency: strobe at edge t -> level=MAX after t+1 -> led_n[i]=0 after t+2.
//  - Full fade time from MAX to 0: LVL_MAX*DECAY_DIV*2**PWM_W cycles, +/- one tick period.
// CONFIGURATION
//  LED_FADE_GAMMA_EN defined:
//    - thr = GAMMA[level], a fixed 16-entry table in the package:
//      0,1,2,4,6,9,13,18,25,33,44,57,74,96,125,255.
//    - level==LVL_MAX is still forced always-on.
//    - Elaboration error unless LVL_W==4 and PWM_W==8.
//  Not defined: linear thr as above; no table is synthesised.
// STRUCTURE
//  Package led_fade_pkg:
//    - LVL_MAX function
//    - GAMMA table constant
//    - lvl_t typedef (logic [LVL_W-1:0])
//  Top holds the shared pwm_cnt, decay_cnt and decay_tick, plus the active OR.
//  Sub-module led_fade_chan, instantiated N_LED times by generate:
//    - inputs: load, decay_tick, pwm_cnt
//    - outputs: led_n bit, level
//    - contents: level register and duty compare
// TESTING (defaults unless noted; DECAY_DIV=2 for speed)
//  1. Reset: rst for 2 cycles -> led_n=8'hFF, active=0.
//     Hold with no strobe for 3 PWM periods -> led_n stays 8'hFF.
//  2. Load: pattern=8'hFE with a pattern_vld pulse at edge t.
//     -> led_n[0]=0 from t+2 onward; other bits remain 1; active=1 at t+2.
//  3. Decay: after test 2, level 14 after 2 periods (thr 224).
//     -> led_n[0]=0 for exactly 224 of 256 cycles.
//     Level reaches 0 after 30 periods -> led_n[0]=1 constantly, active=0.
//  4. Simultaneous: strobe pattern=8'h7F in the same cycle as decay_tick.
//     -> level[7]=15, not 14. Other channels decrement normally.
//     A strobe with pattern=8'hFF leaves all levels unchanged.
//  5. Rotation: drive strobes rotating 8'hFE left one bit every 4 PWM periods.
//     -> a trail of decreasing duties behind the lit LED. Levels never wrap below 0.
//  6. Reset mid-fade at level 9 -> next cycle all levels 0, led_n=8'hFF.
//     With LED_FADE_GAMMA_EN: level 8 -> on 25/256 cycles.

Source files
------------

// File: rtl/led_fade_driver_pkg.sv
// Shared types, constants and helpers for the LED fade driver.
// Build macro LED_FADE_GAMMA_EN adds the gamma brightness table.
package led_fade_pkg;

  localparam int LVL_W_DEF = 4;

  typedef logic [LVL_W_DEF-1:0] lvl_t;

  function automatic int lvl_max(input int lvl_w);
    return (1 << lvl_w) - 1;
  endfunction

`ifdef LED_FADE_GAMMA_EN
  // Perceptual brightness thresholds for a 4-bit level and an 8-bit PWM counter.
  localparam logic [7:0] GAMMA [16] = '{
    8'd0,  8'd1,  8'd2,  8'd4,  8'd6,  8'd9,   8'd13,  8'd18,
    8'd25, 8'd33, 8'd44, 8'd57, 8'd74, 8'd96,  8'd125, 8'd255
  };
`endif

endpackage

// File: rtl/led_fade_driver_if.sv
// Pattern-in / LED-out bundle between the pattern source and the fade driver.
// No configuration macros (LED_FADE_GAMMA_EN does not affect this file).
interface led_fade_driver_if #(
  parameter int N_LED = 8
);

  logic [N_LED-1:0] pattern;
  logic             pattern_vld;
  logic [N_LED-1:0] led_n;
  logic             active;

  modport master (
    output pattern,
    output pattern_vld,
    input  led_n,
    input  active
  );

  modport slave (
    input  pattern,
    input  pattern_vld,
    output led_n,
    output active
  );

endinterface

// File: rtl/led_fade_driver_chan.sv
// One LED channel: brightness level register plus registered PWM duty compare.
// LED_FADE_GAMMA_EN selects the gamma table threshold instead of the linear one.
module led_fade_chan
  import led_fade_pkg::*;
#(
  parameter int LVL_W = 4,
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             decay_tick,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             led_n,
  output logic [LVL_W-1:0] level
);

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(lvl_max(LVL_W));

  logic [LVL_W-1:0] level_q, level_d;
  logic             led_n_q, led_n_d;
  logic [PWM_W-1:0] thr_s;

  // Level update: a load beats a same-cycle decay, decay saturates at zero.
  always_comb begin
    level_d = level_q;
    if (load) begin
      level_d = LVL_MAX;
    end else if (decay_tick && (level_q != {LVL_W{1'b0}})) begin
      level_d = level_q - LVL_W'(1);
    end else begin
      level_d = level_q;
    end
  end

  // Duty threshold for the current level.
  always_comb begin
`ifdef LED_FADE_GAMMA_EN
    thr_s = PWM_W'(GAMMA[level_q]);
`else
    thr_s = PWM_W'(level_q) << (PWM_W - LVL_W);
`endif
  end

  // Full level is forced on; level zero has a zero threshold and never lights.
  always_comb begin
    led_n_d = 1'b1;
    if (level_q == LVL_MAX) begin
      led_n_d = 1'b0;
    end else if (pwm_cnt < thr_s) begin
      led_n_d = 1'b0;
    end else begin
      led_n_d = 1'b1;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= {LVL_W{1'b0}};
      led_n_q <= 1'b1;
    end else begin
      level_q <= level_d;
      led_n_q <= led_n_d;
    end
  end

  assign level = level_q;
  assign led_n = led_n_q;

endmodule

// File: rtl/led_fade_driver.sv
// LED fade driver top: shared PWM/decay timebase, N_LED fade channels, activity flag.
// LED_FADE_GAMMA_EN enables gamma-corrected duty (requires LVL_W==4, PWM_W==8).
module led_fade_driver #(
  parameter int N_LED     = 8,
  parameter int LVL_W     = 4,
  parameter int PWM_W     = 8,
  parameter int DECAY_DIV = 64
) (
  input  logic               clk,
  input  logic               rst,
  led_fade_driver_if.slave   bus
);

  localparam int DEC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_DIV - 1);

`ifdef LED_FADE_GAMMA_EN
  if ((LVL_W != 4) || (PWM_W != 8)) begin : g_gamma_chk
    $error("LED_FADE_GAMMA_EN needs LVL_W==4 and PWM_W==8");
  end
`endif

  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DEC_W-1:0] decay_cnt_q, decay_cnt_d;
  logic             decay_tick_s;
  logic             active_q, active_d;
  logic [N_LED-1:0] load_s;
  logic [N_LED-1:0] led_n_s;
  logic [LVL_W-1:0] level_s [N_LED];

  // Timebase: decay_tick fires on the last PWM wrap of each decay interval.
  always_comb begin
    pwm_cnt_d    = pwm_cnt_q + PWM_W'(1);
    decay_cnt_d  = decay_cnt_q;
    decay_tick_s = 1'b0;
    if (pwm_cnt_q == {PWM_W{1'b1}}) begin
      if (decay_cnt_q == DEC_LAST) begin
        decay_cnt_d  = {DEC_W{1'b0}};
        decay_tick_s = 1'b1;
      end else begin
        decay_cnt_d = decay_cnt_q + DEC_W'(1);
      end
    end else begin
      decay_cnt_d = decay_cnt_q;
    end
  end

  // Any channel still glowing.
  always_comb begin
    active_d = 1'b0;
    for (int i = 0; i < N_LED; i++) begin
      active_d = active_d | (|level_s[i]);
    end
  end

  // Shared timebase and activity registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q   <= {PWM_W{1'b0}};
      decay_cnt_q <= {DEC_W{1'b0}};
      active_q    <= 1'b0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      decay_cnt_q <= decay_cnt_d;
      active_q    <= active_d;
    end
  end

  for (genvar i = 0; i < N_LED; i++) begin : g_chan
    assign load_s[i] = bus.pattern_vld & ~bus.pattern[i];

    led_fade_chan #(
      .LVL_W (LVL_W),
      .PWM_W (PWM_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .load       (load_s[i]),
      .decay_tick (decay_tick_s),
      .pwm_cnt    (pwm_cnt_q),
      .led_n      (led_n_s[i]),
      .level      (level_s[i])
    );
  end

  assign bus.led_n  = led_n_s;
  assign bus.active = active_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Scoreboard bench for led_fade_driver: arithmetic reference model feeds an expected queue,
// a monitor compares every cycle. Honours LED_FADE_GAMMA_EN for the duty thresholds.
module tb_led_fade_driver;

  localparam int N    = 8;
  localparam int PER  = 256;
  localparam int DD   = 2;
  localparam int LMAX = 15;

  logic clk = 1'b0;
  logic rst;

  led_fade_driver_if #(.N_LED(N)) bus ();

  led_fade_driver #(
    .N_LED     (N),
    .LVL_W     (4),
    .PWM_W     (8),
    .DECAY_DIV (DD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         lvl [N];
  int         e;
  logic [8:0] exp_q [$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_print = 0;

  function automatic int thr_of(input int l);
`ifdef LED_FADE_GAMMA_EN
    int g [16] = '{0, 1, 2, 4, 6, 9, 13, 18, 25, 33, 44, 57, 74, 96, 125, 255};
    return g[l];
`else
    return l * (PER / (LMAX + 1));
`endif
  endfunction

  // Reference model: e counts clock edges since reset, so the PWM phase is e mod PER
  // and a decay step lands on every (PER*DD)-th edge.
  initial begin : model
    logic [N-1:0] exp_led;
    logic         exp_act;
    bit           tick;
    e = 0;
    foreach (lvl[i]) lvl[i] = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        foreach (lvl[i]) lvl[i] = 0;
        e = 0;
        exp_q.push_back({8'hFF, 1'b0});
      end else begin
        exp_act = 1'b0;
        for (int i = 0; i < N; i++) begin
          exp_led[i] = !((lvl[i] == LMAX) || ((e % PER) < thr_of(lvl[i])));
          if (lvl[i] != 0) exp_act = 1'b1;
        end
        exp_q.push_back({exp_led, exp_act});
        tick = (((e + 1) % (PER * DD)) == 0);
        for (int i = 0; i < N; i++) begin
          if (bus.pattern_vld && !bus.pattern[i]) lvl[i] = LMAX;
          else if (tick && lvl[i] > 0) lvl[i] = lvl[i] - 1;
        end
        e = e + 1;
      end
    end
  end

  // Monitor: pop one expectation per cycle and compare away from the active edge.
  initial begin : monitor
    logic [8:0] exp_v;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (bus.led_n !== exp_v[8:1]) begin
          n_bad++;
          if (n_print < 40) begin
            n_print++;
            $display("FAIL led_n t=%0t: got %h, want %h", $time, bus.led_n, exp_v[8:1]);
          end
        end
        n_cmp++;
        if (bus.active !== exp_v[0]) begin
          n_bad++;
          if (n_print < 40) begin
            n_print++;
            $display("FAIL active t=%0t: got %b, want %b", $time, bus.active, exp_v[0]);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [N-1:0] p);
    bus.pattern     = p;
    bus.pattern_vld = 1'b1;
    step(1);
    bus.pattern_vld = 1'b0;
    bus.pattern     = N'($urandom);
  endtask

  initial begin : stim
    logic [N-1:0] rot;
    int           guard;
    rst             = 1'b1;
    bus.pattern_vld = 1'b0;
    bus.pattern     = 8'hFF;
    step(2);
    rst = 1'b0;

    // Idle after reset, then a single load followed by a complete fade.
    step(3 * PER);
    strobe(8'hFE);
    step(32 * PER);

    // Load coinciding with a decay tick, then a strobe that lights nothing.
    strobe(8'h00);
    guard = 0;
    while ((((e + 1) % (PER * DD)) != 0) && (guard < PER * DD + 2)) begin
      step(1);
      guard++;
    end
    if (guard >= PER * DD + 2) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tick_wait: waited %0d cycles, limit %0d", guard, PER * DD + 2);
    end
    strobe(8'h7F);
    step(PER);
    strobe(8'hFF);
    step(2 * PER);

    // Rotating pattern leaves a fading trail.
    rot = 8'hFE;
    for (int k = 0; k < 16; k++) begin
      strobe(rot);
      step(4 * PER - 1);
      rot = {rot[6:0], rot[7]};
    end

    // Random strobes and gaps.
    for (int k = 0; k < 50; k++) begin
      if ($urandom_range(0, 3) != 0) strobe(N'($urandom));
      else step(1);
      step($urandom_range(1, 400));
    end

    // Reset in the middle of a fade (all channels near level 9).
    strobe(8'h00);
    step(6 * PER * DD + PER / 2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(PER);
    step(2);

    if (n_cmp == 0) begin
      n_bad++;
      $display("FAIL no_compare: got %0d comparisons, want more than 0", n_cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
